// File: rtl/status_vector_reader.sv
// Packs single status bits pulled from a status value vector into WORD_W-bit words.
// Optional partial-word flush after TIMEOUT idle cycles: define STATUS_READER_TIMEOUT_EN.
module status_vector_reader #(
  parameter  int WORD_W  = 8,
  parameter  int TIMEOUT = 16,
  localparam int CNT_W   = $clog2(WORD_W + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              sv_value_i,
  input  logic              sv_valid_i,
  output logic              sv_pull_o,
  output logic [WORD_W-1:0] word_o,
  output logic [CNT_W-1:0]  count_o,
  output logic [CNT_W-1:0]  ones_o,
  output logic              word_valid_o,
  input  logic              word_ready_i
);

  typedef enum logic {S_COLLECT = 1'b0, S_EMIT = 1'b1} state_t;

  localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(WORD_W - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WORD_W-1:0]  r_sr;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic [CNT_W-1:0]   r_ones_cnt;
  logic               w_pull;
  logic               w_accept;
  logic               w_full;
  logic               w_flush;

  assign w_pull   = (r_state == S_COLLECT) && sv_valid_i && !rst_i;
  assign w_accept = (r_state == S_EMIT) && word_ready_i;
  assign w_full   = w_pull && (r_bit_cnt == LAST_POS);

`ifdef STATUS_READER_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  logic [IDLE_W-1:0] r_idle_cnt;
  logic              w_idle;

  // Only a pending partial word ages; an empty register waits forever.
  assign w_idle  = (r_state == S_COLLECT) && (r_bit_cnt != '0) && !sv_valid_i;
  assign w_flush = w_idle && (r_idle_cnt == IDLE_W'(TIMEOUT - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i || w_accept || w_pull) r_idle_cnt <= '0;
    else if (w_idle)                 r_idle_cnt <= r_idle_cnt + 1'b1;
  end
`else
  assign w_flush = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_COLLECT;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_COLLECT: if (w_full || w_flush) w_state_nxt = S_EMIT;
      S_EMIT:    if (word_ready_i)      w_state_nxt = S_COLLECT;
      default:   w_state_nxt = S_COLLECT;
    endcase
  end

  // Datapath: accept clears, a pull writes the next free bit position.
  always_ff @(posedge clk_i) begin
    if (rst_i || w_accept) begin
      r_sr       <= '0;
      r_bit_cnt  <= '0;
      r_ones_cnt <= '0;
    end else if (w_pull) begin
      for (int i = 0; i < WORD_W; i++)
        if (r_bit_cnt == CNT_W'(i)) r_sr[i] <= sv_value_i;
      r_bit_cnt  <= r_bit_cnt + 1'b1;
      r_ones_cnt <= r_ones_cnt + CNT_W'(sv_value_i);
    end
  end

  assign sv_pull_o    = w_pull;
  assign word_o       = r_sr;
  assign count_o      = r_bit_cnt;
  assign ones_o       = r_ones_cnt;
  assign word_valid_o = (r_state == S_EMIT);

endmodule

// File: tb/tb_status_vector_reader.sv
// Randomized + directed bench for status_vector_reader with a queue scoreboard.
// Expected words come from the offered bit stream grouped into 8-bit words.
module tb_status_vector_reader;

  localparam int WORD_W  = 8;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = $clog2(WORD_W + 1);

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic              sv_value_i = 1'b0;
  logic              sv_valid_i = 1'b0;
  logic              sv_pull_o;
  logic [WORD_W-1:0] word_o;
  logic [CNT_W-1:0]  count_o;
  logic [CNT_W-1:0]  ones_o;
  logic              word_valid_o;
  logic              word_ready_i = 1'b0;

  status_vector_reader #(.WORD_W(WORD_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst_i), .sv_value_i(sv_value_i), .sv_valid_i(sv_valid_i),
    .sv_pull_o(sv_pull_o), .word_o(word_o), .count_o(count_o), .ones_o(ones_o),
    .word_valid_o(word_valid_o), .word_ready_i(word_ready_i)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] w; int c; int o; } exp_t;

  exp_t        exp_q[$];
  bit          src[$];
  logic [31:0] acc_w;
  int          acc_n;
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Stream model: every bit offered goes into the source and the reference word.
  task automatic add_bits(input logic [31:0] data, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      src.push_back(data[i]);
      acc_w[acc_n] = data[i];
      acc_n++;
      if (acc_n == WORD_W) begin
        e.w = acc_w & 32'hFF; e.c = WORD_W; e.o = $countones(acc_w & 32'hFF);
        exp_q.push_back(e);
        acc_w = '0; acc_n = 0;
      end
    end
  endtask

  task automatic flush_model();
    exp_t e;
    if (acc_n > 0) begin
      e.w = acc_w; e.c = acc_n; e.o = $countones(acc_w);
      exp_q.push_back(e);
    end
    acc_w = '0; acc_n = 0;
  endtask

  // One cycle: drive after posedge, sample at negedge, consume on pull.
  task automatic step(input bit ven, input bit rdy, output bit v, output bit pl);
    sv_valid_i   = ven && (src.size() > 0);
    sv_value_i   = (src.size() > 0) ? src[0] : 1'b0;
    word_ready_i = rdy;
    @(negedge clk);
    v  = word_valid_o;
    pl = sv_pull_o;
    @(posedge clk); #1;
    if (pl) void'(src.pop_front());
  endtask

  task automatic do_reset(input int n);
    rst_i = 1'b1; sv_valid_i = 1'b1; sv_value_i = 1'b1; word_ready_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk("rst_pull", sv_pull_o, 0);
        chk("rst_valid", word_valid_o, 0);
        chk("rst_word", word_o, 0);
        chk("rst_count", count_o, 0);
      end
      @(posedge clk); #1;
    end
    rst_i = 1'b0; sv_valid_i = 1'b0;
    acc_w = '0; acc_n = 0; src.delete();
    @(negedge clk);
    chk("post_rst_valid", word_valid_o, 0);
    chk("post_rst_word", word_o, 0);
    chk("post_rst_count", count_o, 0);
    chk("post_rst_ones", ones_o, 0);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    bit v, pl;
    int n = 0;
    while ((exp_q.size() > 0 || src.size() > 0) && n < 3000) begin
      step(1'b1, 1'b1, v, pl);
      n++;
    end
    chk("drain_bound", (n < 3000), 1);
  endtask

  // Monitor: protocol checks every cycle, scoreboard pop on each accepted word.
  bit          p_valid = 0, p_ready = 0;
  logic [31:0] p_word, p_cnt, p_ones;

  always @(negedge clk) begin
    exp_t e;
    if (rst_i) begin
      p_valid = 0;
    end else begin
      if (word_valid_o === 1'b1) begin
        chk("emit_no_pull", sv_pull_o, 0);
        if (p_valid && !p_ready) begin
          chk("hold_word", word_o, p_word);
          chk("hold_count", count_o, p_cnt);
          chk("hold_ones", ones_o, p_ones);
        end
        if (word_ready_i) begin
          if (exp_q.size() == 0) chk("unexpected_word", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("word", word_o, e.w);
            chk("count", count_o, e.c);
            chk("ones", ones_o, e.o);
          end
        end
      end else if (sv_valid_i) begin
        chk("collect_pull", sv_pull_o, 1);
      end
      if (count_o > CNT_W'(WORD_W)) chk("count_range", count_o, WORD_W);
      if (ones_o > count_o)         chk("ones_le_count", ones_o, count_o);
      p_valid = (word_valid_o === 1'b1);
      p_ready = word_ready_i;
      p_word = word_o; p_cnt = count_o; p_ones = ones_o;
    end
  end

  initial begin
    bit v, pl;
    int first, lows;
    acc_w = '0; acc_n = 0;

    do_reset(4);

    // Full word 0x4D, then backpressure with more data waiting.
    add_bits(32'h4D, 8);
    add_bits($urandom & 32'hFF, 8);
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 1'b0, v, pl);
      chk("fill_no_valid", v, 0);
    end
    step(1'b1, 1'b0, v, pl);
    chk("emit_latency", v, 1);
    chk("emit_word_4d", word_o, 32'h4D);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, v, pl);
    step(1'b1, 1'b1, v, pl);
    chk("accept_cycle_valid", v, 1);
    step(1'b1, 1'b1, v, pl);
    chk("pull_after_accept", pl, 1);
    drain();

    // Partial word then idle.
    do_reset(4);
    add_bits(32'h7, 3);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, v, pl);
`ifdef STATUS_READER_TIMEOUT_EN
    flush_model();
`endif
    first = 0;
    for (int k = 1; k <= 100; k++) begin
      step(1'b0, 1'b1, v, pl);
      if (v && first == 0) first = k;
    end
`ifdef STATUS_READER_TIMEOUT_EN
    chk("timeout_latency", first, 17);
`else
    chk("no_flush", first, 0);
`endif

    // Idle interrupted by a pull restarts the idle window.
    do_reset(4);
    add_bits(32'h3, 2);
    for (int k = 0; k < 2; k++) step(1'b1, 1'b1, v, pl);
    first = 0;
    for (int k = 1; k <= 15; k++) begin
      step(1'b0, 1'b1, v, pl);
      if (v && first == 0) first = k;
    end
    chk("no_early_flush", first, 0);
    add_bits(32'h0, 1);
    step(1'b1, 1'b1, v, pl);
    chk("third_pull", pl, 1);
`ifdef STATUS_READER_TIMEOUT_EN
    flush_model();
`endif
    first = 0;
    for (int k = 1; k <= 40; k++) begin
      step(1'b0, 1'b1, v, pl);
      if (v && first == 0) first = k;
    end
`ifdef STATUS_READER_TIMEOUT_EN
    chk("restart_latency", first, 17);
`else
    chk("restart_no_flush", first, 0);
`endif

    // Reset in the middle of a word discards it.
    do_reset(4);
    add_bits(32'h1F, 5);
    for (int k = 0; k < 5; k++) step(1'b1, 1'b1, v, pl);
    do_reset(1);
    add_bits(32'h80, 8);
    drain();

    // Random traffic; idle gaps kept short so only full words appear.
    do_reset(2);
    lows = 0;
    for (int k = 0; k < 600; k++) begin
      bit ven;
      if (src.size() < 4) add_bits($urandom & 32'hFF, 8);
      ven = ($urandom_range(0, 2) != 0) || (lows >= 8);
      lows = ven ? 0 : lows + 1;
      step(ven, ($urandom_range(0, 3) != 0), v, pl);
    end
    drain();
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/status_vector_reader.md
STATUS_VECTOR_READER -- requirements
Module: status_vector_reader

Interface
REQ-001 Parameter WORD_W, default 8: number of status bits packed per output word; legal range 2..32.
REQ-002 Parameter TIMEOUT, default 16: number of consecutive idle cycles before a partial word is flushed; legal range 1..255.
REQ-003 Derived width CNT_W = clog2(WORD_W+1).
REQ-004 clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 rst_i  input  1  reset; synchronous, active-high.
REQ-006 sv_value_i  input  1  head-entry value from the status value vector.
REQ-007 sv_valid_i  input  1  status value vector holds at least one entry.
REQ-008 sv_pull_o  output  1  pops the head entry at the next rising edge.
REQ-009 word_o  output  WORD_W  packed bits, first-pulled bit at bit 0; unfilled bits are 0.
REQ-010 count_o  output  CNT_W  number of valid bits in word_o.
REQ-011 ones_o  output  CNT_W  number of 1 bits in word_o.
REQ-012 word_valid_o  output  1  word_o, count_o and ones_o are valid.
REQ-013 word_ready_i  input  1  downstream accepts the word when high together with word_valid_o.

Function
REQ-014 The FSM SHALL have exactly two states: COLLECT and EMIT; reset state is COLLECT.
REQ-015 sv_pull_o SHALL be combinational: high iff state==COLLECT, sv_valid_i==1 and rst_i==0.
REQ-016 On each edge with sv_pull_o high, sv_value_i SHALL be written to bit position bit_cnt of the shift register, bit_cnt SHALL increment, and ones_cnt SHALL increment if the value is 1.
REQ-017 When the pull that fills bit position WORD_W-1 occurs, the FSM SHALL enter EMIT; word_valid_o SHALL be high in the cycle after that pull (1-cycle latency).
REQ-018 In EMIT, sv_pull_o SHALL be 0, and word_o, count_o and ones_o SHALL be held stable until word_ready_i==1.
REQ-019 On an edge with word_valid_o and word_ready_i both high, the FSM SHALL return to COLLECT and clear the shift register, bit_cnt, ones_cnt and idle_cnt; no pull occurs in that cycle.
REQ-020 word_valid_o SHALL equal (state==EMIT), registered.
REQ-021 word_o, count_o and ones_o SHALL be driven directly from the shift register, bit_cnt and ones_cnt in both states.
REQ-022 bit_cnt SHALL never exceed WORD_W; ones_cnt SHALL never exceed bit_cnt.
REQ-023 In COLLECT with bit_cnt==0, the block SHALL remain in COLLECT indefinitely and emit nothing.

Reset
REQ-024 When rst_i is high at an edge, the block SHALL force state=COLLECT and clear the shift register, bit_cnt, ones_cnt and idle_cnt, regardless of state.
REQ-025 After reset, the outputs SHALL be: word_o=0, count_o=0, ones_o=0, word_valid_o=0; sv_pull_o SHALL be 0 while rst_i is high.
REQ-026 If reset occurs mid-collection or during EMIT, partial and pending words SHALL be discarded without emission.

Configuration
REQ-027 Macro STATUS_READER_TIMEOUT_EN, when defined, SHALL compile in the partial-word flush:
- idle_cnt increments on each COLLECT cycle with bit_cnt>0 and sv_valid_i==0.
- idle_cnt clears on any pull.
- On the TIMEOUT-th consecutive idle cycle, the FSM enters EMIT with the current partial count.
REQ-028 Without STATUS_READER_TIMEOUT_EN:
- idle_cnt SHALL not exist.
- Only full WORD_W words SHALL be emitted.
- Behaviour SHALL be otherwise identical.

Verification (WORD_W=8, TIMEOUT=16)
REQ-029 Reset scenario: hold rst_i=1 for 4 cycles with sv_valid_i=1 -> sv_pull_o=0, word_valid_o=0, word_o=0x00, count_o=0.
REQ-030 Full-word scenario: pull bits 1,0,1,1,0,0,1,0 back-to-back -> word_valid_o=1 one cycle after the 8th pull, word_o=0x4D, count_o=8, ones_o=4.
REQ-031 Backpressure scenario: hold word_ready_i=0 for 5 cycles during EMIT with sv_valid_i=1 -> word_o stays 0x4D, sv_pull_o=0; after the accept edge, sv_pull_o=1 the next cycle.
REQ-032 Timeout scenario: pull 1,1,1, then sv_valid_i=0 -> with the macro defined, word_valid_o=1 after 16 idle cycles with word_o=0x07, count_o=3, ones_o=3; without the macro, no emission within 100 cycles.
REQ-033 Mid-collection reset scenario: pull 5 bits of 1, pulse rst_i, then pull 0,0,0,0,0,0,0,1 -> word_o=0x80, count_o=8, ones_o=1.
REQ-034 Idle-interruption scenario: pull 2 bits of 1, hold sv_valid_i=0 for 15 cycles, pull one 0, hold idle again -> with the macro defined, flush occurs 16 cycles after the 3rd pull with word_o=0x03, count_o=3, ones_o=2.
